// File: rtl/golden_nonce_reporter.sv
// Captures golden nonces from the miner core into a small result FIFO tagged
// with the current job, counting accepted and dropped results.
module golden_nonce_reporter #(
  parameter int DEPTH = 4,
  parameter int JOB_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_work,
  input  logic [31:0]                golden_nonce,
  input  logic                       golden_nonce_ticket,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [31:0]                result_nonce,
  output logic [JOB_W-1:0]           result_job,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 drop_count,
  output logic [15:0]                found_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_HOLDING = 2'd1,
    S_FULL    = 2'd2
  } fifo_state_t;

  fifo_state_t      state;
  logic [31:0]      nonce_mem [DEPTH];
  logic [JOB_W-1:0] job_mem   [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [JOB_W-1:0] job_tag;
  logic [31:0]      last_nonce;
  logic             last_valid;
  logic             ticket_q;
  logic             full;
  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;

  function automatic fifo_state_t state_of(input logic [CW-1:0] c);
    if (c == '0)
      return S_EMPTY;
    else if (c == CW'(DEPTH))
      return S_FULL;
    else
      return S_HOLDING;
  endfunction

  // A ticket held high with the same nonce is one result, not many.
  assign capture = golden_nonce_ticket &&
                   (!ticket_q || !last_valid || (golden_nonce != last_nonce));
  assign full    = (state == S_FULL);
  assign pop     = result_valid && result_ready && !new_work;
  assign push    = capture && !new_work && (!full || pop);
  assign drop    = capture && !new_work && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      job_tag     <= '0;
      last_nonce  <= '0;
      last_valid  <= 1'b0;
      ticket_q    <= 1'b0;
      drop_count  <= '0;
      found_count <= '0;
    end else begin
      ticket_q <= golden_nonce_ticket;
      if (new_work) begin
        state      <= S_EMPTY;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        job_tag    <= job_tag + 1'b1;
        last_valid <= 1'b0;
      end else begin
        // History follows every capture event, dropped or not.
        if (capture) begin
          last_nonce <= golden_nonce;
          last_valid <= 1'b1;
        end
        if (push) begin
          nonce_mem[wr_ptr] <= golden_nonce;
          job_mem[wr_ptr]   <= job_tag;
          wr_ptr            <= wr_ptr + 1'b1;
          found_count       <= found_count + 16'd1;
        end
        if (drop && (drop_count != 8'hFF))
          drop_count <= drop_count + 8'd1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
        state <= state_of(count_nxt);
      end
    end
  end

  assign fifo_count   = count;
  assign result_valid = (state != S_EMPTY);
  // Gate the head so stale storage never shows after reset or flush.
  assign result_nonce = result_valid ? nonce_mem[rd_ptr] : '0;
  assign result_job   = result_valid ? job_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter with hand-computed expectations.
module tb_golden_nonce_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_work;
  logic [31:0] golden_nonce;
  logic        golden_nonce_ticket;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_nonce;
  logic [3:0]  result_job;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;
  logic [15:0] found_count;

  int passed = 0;
  int total  = 0;

  golden_nonce_reporter #(.DEPTH(4), .JOB_W(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .new_work            (new_work),
    .golden_nonce        (golden_nonce),
    .golden_nonce_ticket (golden_nonce_ticket),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_nonce        (result_nonce),
    .result_job          (result_job),
    .fifo_count          (fifo_count),
    .drop_count          (drop_count),
    .found_count         (found_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    new_work = 1'b0;
    golden_nonce = '0;
    golden_nonce_ticket = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_nonce", result_nonce, 0);
    chk("rst_job", 32'(result_job), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_found", 32'(found_count), 0);
    reset = 1'b0;

    // Ticket held three cycles with one nonce yields a single entry.
    golden_nonce = 32'h0E33337A;
    golden_nonce_ticket = 1'b1;
    tick();
    chk("lat_valid", 32'(result_valid), 1);
    tick();
    tick();
    golden_nonce_ticket = 1'b0;
    tick();
    chk("hold_count", 32'(fifo_count), 1);
    chk("hold_nonce", result_nonce, 32'h0E33337A);
    chk("hold_job", 32'(result_job), 0);
    chk("hold_found", 32'(found_count), 1);
    result_ready = 1'b1;
    tick();
    chk("pop1_count", 32'(fifo_count), 0);
    chk("pop1_valid", 32'(result_valid), 0);
    result_ready = 1'b0;

    // Six distinct tickets into a depth-4 FIFO.
    golden_nonce_ticket = 1'b1;
    for (int i = 0; i < 6; i++) begin
      golden_nonce = 32'h100 + 32'(i);
      tick();
    end
    golden_nonce_ticket = 1'b0;
    tick();
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_drop", 32'(drop_count), 2);
    chk("ovf_found", 32'(found_count), 5);
    tick();
    chk("ovf_stable", result_nonce, 32'h100);
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_a%0d", i), result_nonce, 32'h100 + 32'(i));
      tick();
    end
    chk("drain_a_count", 32'(fifo_count), 0);
    result_ready = 1'b0;

    // Full FIFO: capture and pop in the same cycle.
    golden_nonce_ticket = 1'b1;
    for (int i = 0; i < 4; i++) begin
      golden_nonce = 32'h200 + 32'(i);
      tick();
    end
    chk("full_count", 32'(fifo_count), 4);
    golden_nonce = 32'h204;
    result_ready = 1'b1;
    tick();
    golden_nonce_ticket = 1'b0;
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_drop", 32'(drop_count), 2);
    chk("pp_found", 32'(found_count), 10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_b%0d", i), result_nonce, 32'h201 + 32'(i));
      tick();
    end
    chk("drain_b_count", 32'(fifo_count), 0);
    result_ready = 1'b0;

    // Ticket re-raised with the same nonce after going low is a new capture.
    golden_nonce = 32'h204;
    golden_nonce_ticket = 1'b1;
    tick();
    golden_nonce_ticket = 1'b0;
    tick();
    chk("rearm_count", 32'(fifo_count), 1);
    chk("rearm_nonce", result_nonce, 32'h204);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // new_work with a ticket in the same cycle flushes and ignores the ticket.
    golden_nonce_ticket = 1'b1;
    golden_nonce = 32'h300;
    tick();
    golden_nonce = 32'h301;
    tick();
    chk("nw_pre_count", 32'(fifo_count), 2);
    golden_nonce = 32'h302;
    new_work = 1'b1;
    result_ready = 1'b1;
    tick();
    new_work = 1'b0;
    result_ready = 1'b0;
    golden_nonce_ticket = 1'b0;
    chk("nw_count", 32'(fifo_count), 0);
    chk("nw_valid", 32'(result_valid), 0);
    chk("nw_found", 32'(found_count), 13);
    golden_nonce = 32'h303;
    golden_nonce_ticket = 1'b1;
    tick();
    golden_nonce_ticket = 1'b0;
    chk("nw_job", 32'(result_job), 1);
    chk("nw_nonce", result_nonce, 32'h303);
    chk("nw_count2", 32'(fifo_count), 1);

    // Fifteen more new_work pulses wrap the job tag back to zero.
    for (int i = 0; i < 15; i++) begin
      new_work = 1'b1;
      tick();
      new_work = 1'b0;
      tick();
    end
    golden_nonce_ticket = 1'b1;
    for (int i = 0; i < 4; i++) begin
      golden_nonce = 32'h400 + 32'(i);
      tick();
    end
    chk("wrap_job", 32'(result_job), 0);
    chk("wrap_head", result_nonce, 32'h400);
    for (int i = 0; i < 300; i++) begin
      golden_nonce = 32'h500 + 32'(i);
      tick();
    end
    golden_nonce_ticket = 1'b0;
    tick();
    chk("sat_drop", 32'(drop_count), 32'hFF);
    chk("sat_found", 32'(found_count), 18);
    chk("sat_count", 32'(fifo_count), 4);

    // Reset with three entries held and the host ready.
    result_ready = 1'b1;
    tick();
    chk("pre_rst_count", 32'(fifo_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_valid", 32'(result_valid), 0);
    chk("mid_rst_nonce", result_nonce, 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    chk("mid_rst_found", 32'(found_count), 0);
    tick();
    chk("post_rst_valid", 32'(result_valid), 0);
    result_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/golden_nonce_reporter.md
GOLDEN_NONCE_REPORTER -- requirements
Module: golden_nonce_reporter

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, result FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter JOB_W, default 4, job-tag width.
REQ-003 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide new_work  input  1  one-cycle pulse when new midstate/data/nonce is loaded into the miner.
REQ-006 SHALL provide golden_nonce  input  32  nonce reported by the miner core.
REQ-007 SHALL provide golden_nonce_ticket  input  1  miner found-flag; may stay high for several cycles with the same nonce.
REQ-008 SHALL provide result_valid  output  1  FIFO head holds a result.
REQ-009 SHALL provide result_ready  input  1  host accepts head entry.
REQ-010 SHALL provide result_nonce  output  32  head-entry nonce.
REQ-011 SHALL provide result_job  output  JOB_W  job tag of head entry.
REQ-012 SHALL provide fifo_count  output  $clog2(DEPTH)+1  entries held.
REQ-013 SHALL provide drop_count  output  8  results lost to a full FIFO, saturating.
REQ-014 SHALL provide found_count  output  16  results accepted into the FIFO, wrapping.

Function
REQ-015 Capture event SHALL be: golden_nonce_ticket high AND (ticket low in previous cycle OR golden_nonce differs from last captured nonce).
REQ-016 On a capture event with FIFO not full, {current job tag, golden_nonce} SHALL be written; fifo_count and found_count increment next cycle.
REQ-017 On a capture event with FIFO full and no pop in the same cycle, the entry SHALL be discarded and drop_count incremented, saturating at 8'hFF.
REQ-018 Pop SHALL occur when result_valid AND result_ready; head advances next cycle.
REQ-019 Simultaneous push and pop SHALL both succeed, including when full; fifo_count unchanged.
REQ-020 result_valid SHALL equal (fifo_count != 0); result_nonce/result_job SHALL be stable while result_valid high and result_ready low.
REQ-021 Write-to-valid latency SHALL be 1 cycle (capture in cycle N -> result_valid in N+1 if previously empty).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 new_work SHALL flush the FIFO (count to 0), increment job tag modulo 2^JOB_W, and clear the last-captured-nonce history; drop_count and found_count are retained.
REQ-024 new_work SHALL take priority: a ticket or pop in the same cycle as new_work is ignored (ticket belongs to the old job).
REQ-025 The first ticket after new_work SHALL be tagged with the incremented job tag.
REQ-026 Internal state SHALL be: EMPTY / HOLDING / FULL, derived from fifo_count; no other control FSM is required.

Reset
REQ-027 On reset: fifo_count=0, result_valid=0, result_nonce=0, result_job=0, job tag=0, drop_count=0, found_count=0, pointers=0, history cleared.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries within one cycle and override new_work, ticket and pop.

Verification
REQ-029 Ticket high 3 cycles with nonce 32'h0E33337A, result_ready=0 -> exactly one entry; fifo_count=1, result_nonce=32'h0E33337A, result_job=0, found_count=1.
REQ-030 Six distinct single-cycle tickets, result_ready=0, DEPTH=4 -> fifo_count=4, drop_count=2; draining yields the first four nonces in order.
REQ-031 FIFO full, capture and pop in the same cycle -> fifo_count stays 4, drop_count unchanged, new nonce appears as fourth read.
REQ-032 Two entries held, pulse new_work together with a ticket -> fifo_count=0, result_valid=0, ticket ignored; next ticket tagged result_job=1.
REQ-033 Sixteen new_work pulses with JOB_W=4 -> job tag wraps to 0; 300 overflow drops -> drop_count=8'hFF.
REQ-034 Reset asserted with three entries held and result_ready=1 -> next cycle all outputs zero, no entry delivered.
